// File: rtl/uart_program_loader_pkg.sv
// Shared types and defaults for the UART program loader: FSM states, memory size, idle timeout.
package uart_program_loader_pkg;

    typedef enum logic [1:0] {
        LD_IDLE,
        LD_RECEIVE,
        LD_DONE
    } loader_state_t;

    localparam int PRG_MEM_WORDS       = 256;
    localparam int LOADER_IDLE_TIMEOUT = 400000000;
    localparam int LOADER_CNT_WIDTH    = 29;
    localparam int BYTES_PER_WORD      = 4;

    function automatic logic [31:0] word_byte_address(input logic [31:0] word_index);
        return word_index << 2;
    endfunction

endpackage

// File: rtl/uart_program_loader_if.sv
// Byte stream in, program memory write port and load status out.
interface uart_program_loader_if #(
    parameter int MEM_WORDS = 256
);
    localparam int WC_W = $clog2(MEM_WORDS) + 1;

    logic            byte_valid;
    logic [7:0]      byte_data;
    logic            prg_write_enable;
    logic [31:0]     prg_byte_address;
    logic [31:0]     prg_write_data;
    logic [WC_W-1:0] word_count;
    logic            load_done;
    logic            partial_error;
    logic            overflow_error;

    // master: UART receiver / system side; slave: the loader
    modport master (
        output byte_valid, byte_data,
        input  prg_write_enable, prg_byte_address, prg_write_data,
        input  word_count, load_done, partial_error, overflow_error
    );

    modport slave (
        input  byte_valid, byte_data,
        output prg_write_enable, prg_byte_address, prg_write_data,
        output word_count, load_done, partial_error, overflow_error
    );
endinterface

// File: rtl/uart_program_loader_byte_packer.sv
// Packs accepted bytes MSB-first; the fourth byte bypasses storage so the full word is ready the same cycle.
module uart_program_loader_byte_packer
    import uart_program_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        accept_i,
    input  logic [7:0]  byte_i,
    output logic [1:0]  byte_index_o,
    output logic        word_ready_o,
    output logic [31:0] word_o
);
    localparam logic [1:0] LAST_INDEX = 2'(BYTES_PER_WORD - 1);

    logic [1:0] byte_index_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_index_q <= 2'd0;
        end else if (accept_i) begin
            byte_index_q <= byte_index_q + 2'd1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < BYTES_PER_WORD - 1; gi++) begin : g_lane
            logic [7:0] lane_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    lane_q <= 8'd0;
                end else if (accept_i && byte_index_q == 2'(gi)) begin
                    lane_q <= byte_i;
                end
            end

            assign word_o[31-8*gi -: 8] = lane_q;
        end
    endgenerate

    assign word_o[7:0]  = byte_i;
    assign word_ready_o = accept_i && (byte_index_q == LAST_INDEX);
    assign byte_index_o = byte_index_q;

endmodule

// File: rtl/uart_program_loader.sv
// Boot-time loader: packs UART bytes into words, writes them to program memory, then raises load_done.
module uart_program_loader
    import uart_program_loader_pkg::*;
#(
    parameter int MEM_WORDS    = PRG_MEM_WORDS,
    parameter int IDLE_TIMEOUT = LOADER_IDLE_TIMEOUT,
    parameter int CNT_WIDTH    = LOADER_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    uart_program_loader_if.slave  bus
);
    localparam int WC_W = $clog2(MEM_WORDS) + 1;
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_CNT = CNT_WIDTH'(IDLE_TIMEOUT);
    localparam logic [WC_W-1:0]      FULL_CNT    = WC_W'(MEM_WORDS);

    loader_state_t        state_q;
    logic [CNT_WIDTH-1:0] idle_cnt_q;
    logic [WC_W-1:0]      word_index_q;
    logic                 write_enable_q;
    logic [31:0]          byte_address_q;
    logic [31:0]          write_data_q;
    logic                 load_done_q;
    logic                 partial_error_q;
    logic                 overflow_error_q;

    logic        full;
    logic        accept;
    logic        timeout;
    logic [1:0]  byte_index;
    logic        word_ready;
    logic [31:0] packed_word;

    // Once full, bytes are refused even before the FSM has reached DONE.
    assign full    = (word_index_q == FULL_CNT);
    assign accept  = bus.byte_valid && (state_q != LD_DONE) && !full;
    assign timeout = (state_q != LD_DONE) && (idle_cnt_q == TIMEOUT_CNT) && !bus.byte_valid;

    uart_program_loader_byte_packer u_packer (
        .clk          (clk),
        .reset        (reset),
        .accept_i     (accept),
        .byte_i       (bus.byte_data),
        .byte_index_o (byte_index),
        .word_ready_o (word_ready),
        .word_o       (packed_word)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= LD_IDLE;
            idle_cnt_q       <= '0;
            word_index_q     <= '0;
            write_enable_q   <= 1'b0;
            byte_address_q   <= 32'd0;
            write_data_q     <= 32'd0;
            load_done_q      <= 1'b0;
            partial_error_q  <= 1'b0;
            overflow_error_q <= 1'b0;
        end else begin
            write_enable_q <= 1'b0;
            if (word_ready) begin
                write_enable_q <= 1'b1;
                byte_address_q <= word_byte_address(32'(word_index_q));
                write_data_q   <= packed_word;
                word_index_q   <= word_index_q + 1'b1;
            end

            if (state_q != LD_DONE) begin
                if (accept) begin
                    idle_cnt_q <= '0;
                end else if (idle_cnt_q != TIMEOUT_CNT) begin
                    idle_cnt_q <= idle_cnt_q + 1'b1;
                end
            end

            case (state_q)
                LD_IDLE: begin
                    if (timeout) begin
                        state_q     <= LD_DONE;
                        load_done_q <= 1'b1;
                    end else if (accept) begin
                        state_q <= LD_RECEIVE;
                    end
                end
                LD_RECEIVE: begin
                    if (full) begin
                        state_q     <= LD_DONE;
                        load_done_q <= 1'b1;
                        if (bus.byte_valid) begin
                            overflow_error_q <= 1'b1;
                        end
                    end else if (timeout) begin
                        state_q     <= LD_DONE;
                        load_done_q <= 1'b1;
                        if (byte_index != 2'd0) begin
                            partial_error_q <= 1'b1;
                        end
                    end
                end
                LD_DONE: begin
                    if (bus.byte_valid) begin
                        overflow_error_q <= 1'b1;
                    end
                end
                default: state_q <= LD_IDLE;
            endcase
        end
    end

    assign bus.prg_write_enable = write_enable_q;
    assign bus.prg_byte_address = byte_address_q;
    assign bus.prg_write_data   = write_data_q;
    assign bus.word_count       = word_index_q;
    assign bus.load_done        = load_done_q;
    assign bus.partial_error    = partial_error_q;
    assign bus.overflow_error   = overflow_error_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader with a 4-word memory and an 8-cycle idle timeout.
module tb_uart_program_loader;
    localparam int MEM_WORDS = 4;
    localparam int IDLE      = 8;
    localparam int CNT_W     = 4;
    localparam int WC_W      = $clog2(MEM_WORDS) + 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    uart_program_loader_if #(.MEM_WORDS(MEM_WORDS)) bus ();

    uart_program_loader #(
        .MEM_WORDS   (MEM_WORDS),
        .IDLE_TIMEOUT(IDLE),
        .CNT_WIDTH   (CNT_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic            bv;
        logic [7:0]      d;
        logic            we;
        logic [31:0]     addr;
        logic [31:0]     data;
        logic [WC_W-1:0] wc;
        logic            done;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    vec_t vecs [13];
    wr_t  wlog [$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.prg_write_enable) begin
            wlog.push_back('{bus.prg_byte_address, bus.prg_write_data, cyc});
            $display("write: addr=%h data=%h cycle=%0d", bus.prg_byte_address, bus.prg_write_data, cyc);
        end
        if (bus.load_done && done_cyc < 0) done_cyc = cyc;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        step();
        bus.byte_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        bus.byte_valid = 1'b0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        wlog.delete();
        done_cyc = -1;
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (!bus.load_done && n < budget) begin
            step();
            n++;
        end
        check("done_within_budget", 32'(bus.load_done), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"},   32'(bus.prg_write_enable), 32'd0);
        check({tag, "_addr"}, bus.prg_byte_address, 32'd0);
        check({tag, "_data"}, bus.prg_write_data, 32'd0);
        check({tag, "_wc"},   32'(bus.word_count), 32'd0);
        check({tag, "_done"}, 32'(bus.load_done), 32'd0);
        check({tag, "_perr"}, 32'(bus.partial_error), 32'd0);
        check({tag, "_oerr"}, 32'(bus.overflow_error), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [31:0] w;

        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'd0;
        reset = 1'b1;
        step();
        step();
        check_all_zero("reset");
        reset = 1'b0;

        // Four bytes back-to-back, one write, then idle into timeout.
        vecs[0] = '{1'b1, 8'h00, 1'b0, 32'h0, 32'h0, WC_W'(0), 1'b0};
        vecs[1] = '{1'b1, 8'h50, 1'b0, 32'h0, 32'h0, WC_W'(0), 1'b0};
        vecs[2] = '{1'b1, 8'h00, 1'b0, 32'h0, 32'h0, WC_W'(0), 1'b0};
        vecs[3] = '{1'b1, 8'h93, 1'b1, 32'h0, 32'h00500093, WC_W'(1), 1'b0};
        for (int i = 4; i < 12; i++)
            vecs[i] = '{1'b0, 8'h00, 1'b0, 32'h0, 32'h00500093, WC_W'(1), 1'b0};
        vecs[12] = '{1'b0, 8'h00, 1'b0, 32'h0, 32'h00500093, WC_W'(1), 1'b1};

        for (int i = 0; i < 13; i++) begin
            bus.byte_valid = vecs[i].bv;
            bus.byte_data  = vecs[i].d;
            step();
            bus.byte_valid = 1'b0;
            $display("vec %0d: bv=%0b d=%h -> we=%0b addr=%h data=%h wc=%0d done=%0b",
                     i, vecs[i].bv, vecs[i].d, bus.prg_write_enable, bus.prg_byte_address,
                     bus.prg_write_data, bus.word_count, bus.load_done);
            check($sformatf("v%0d_we", i),   32'(bus.prg_write_enable), 32'(vecs[i].we));
            check($sformatf("v%0d_addr", i), bus.prg_byte_address, vecs[i].addr);
            check($sformatf("v%0d_data", i), bus.prg_write_data, vecs[i].data);
            check($sformatf("v%0d_wc", i),   32'(bus.word_count), 32'(vecs[i].wc));
            check($sformatf("v%0d_done", i), 32'(bus.load_done), 32'(vecs[i].done));
            check($sformatf("v%0d_perr", i), 32'(bus.partial_error), 32'd0);
            check($sformatf("v%0d_oerr", i), 32'(bus.overflow_error), 32'd0);
        end

        // Spaced bytes: idle counter must clear on each byte.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            send(8'(8'h11 * (i + 1)));
            idle(2);
        end
        check("spaced_nwrites", 32'(wlog.size()), 32'd2);
        if (wlog.size() == 2) begin
            check("spaced_w0_addr", wlog[0].addr, 32'h0);
            check("spaced_w0_data", wlog[0].data, 32'h11223344);
            check("spaced_w1_addr", wlog[1].addr, 32'h4);
            check("spaced_w1_data", wlog[1].data, 32'h55667788);
        end
        check("spaced_no_early_done", 32'(bus.load_done), 32'd0);
        check("spaced_wc", 32'(bus.word_count), 32'd2);
        wait_done(30, n);
        check("spaced_perr", 32'(bus.partial_error), 32'd0);

        // Fill the whole memory back-to-back, then overflow.
        do_reset();
        for (int i = 0; i < 16; i++) send(8'(8'hA0 + i));
        idle(3);
        check("full_nwrites", 32'(wlog.size()), 32'd4);
        if (wlog.size() == 4) begin
            for (int j = 0; j < 4; j++) begin
                w = 32'd0;
                for (int k = 0; k < 4; k++) w = {w[23:0], 8'(8'hA0 + 4 * j + k)};
                check($sformatf("full_w%0d_addr", j), wlog[j].addr, 32'(4 * j));
                check($sformatf("full_w%0d_data", j), wlog[j].data, w);
            end
            check("full_done_cycle", 32'(done_cyc), 32'(wlog[3].cyc + 1));
        end
        check("full_done", 32'(bus.load_done), 32'd1);
        check("full_wc", 32'(bus.word_count), 32'(MEM_WORDS));
        check("full_oerr_before", 32'(bus.overflow_error), 32'd0);
        send(8'hFF);
        idle(2);
        check("full_oerr_after", 32'(bus.overflow_error), 32'd1);
        check("full_no_extra_write", 32'(wlog.size()), 32'd4);
        check("full_perr", 32'(bus.partial_error), 32'd0);

        // Partial word then silence.
        do_reset();
        send(8'hAB);
        send(8'hCD);
        wait_done(30, n);
        check("partial_done_latency", 32'(n), 32'(IDLE + 1));
        check("partial_perr", 32'(bus.partial_error), 32'd1);
        check("partial_wc", 32'(bus.word_count), 32'd0);
        check("partial_nwrites", 32'(wlog.size()), 32'd0);
        check("partial_oerr", 32'(bus.overflow_error), 32'd0);

        // Byte arriving exactly on the terminal idle count wins.
        do_reset();
        idle(IDLE);
        send(8'h5A);
        check("coincide_done", 32'(bus.load_done), 32'd0);
        idle(IDLE);
        check("coincide_done_later", 32'(bus.load_done), 32'd0);
        step();
        check("coincide_timeout", 32'(bus.load_done), 32'd1);
        check("coincide_perr", 32'(bus.partial_error), 32'd1);

        // No bytes at all: done exactly IDLE+1 cycles after release.
        do_reset();
        wait_done(30, n);
        check("empty_done_latency", 32'(n), 32'(IDLE + 1));
        check("empty_perr", 32'(bus.partial_error), 32'd0);
        check("empty_wc", 32'(bus.word_count), 32'd0);

        // Asynchronous reset mid-load, then reload from address 0.
        do_reset();
        for (int i = 0; i < 6; i++) send(8'(8'hC0 + i));
        check("midreset_pre_wc", 32'(bus.word_count), 32'd1);
        check("midreset_pre_data", bus.prg_write_data, 32'hC0C1C2C3);
        #3;
        reset = 1'b1;
        #1;
        check_all_zero("midreset");
        step();
        reset = 1'b0;
        wlog.delete();
        for (int i = 0; i < 4; i++) send(8'(8'hD0 + i));
        step();
        check("reload_nwrites", 32'(wlog.size()), 32'd1);
        if (wlog.size() == 1) begin
            check("reload_addr", wlog[0].addr, 32'h0);
            check("reload_data", wlog[0].data, 32'hD0D1D2D3);
        end
        check("reload_wc", 32'(bus.word_count), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_program_loader.md
Name: uart_program_loader

Overview:
- Sits between the UART byte receiver and the program memory write port; active only before the CPU pipeline is released.
- Packs incoming bytes MSB-first into 32-bit instruction words and issues one-cycle word writes at consecutive word-aligned byte addresses.
- Asserts load_done when the memory is full or the line has been idle for IDLE_TIMEOUT cycles. load_done releases the pipeline and hands program memory address control to the CPU.

Parameters:
MEM_WORDS, 256, number of 32-bit words in program memory; a load stops after this many words.
IDLE_TIMEOUT, 400000000, cycles without a byte before load_done; counted from reset or from the last accepted byte.
CNT_WIDTH, 29, width of the idle counter; must hold IDLE_TIMEOUT.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
byte_valid  input  1  one-cycle strobe from the UART receiver; byte_data is valid this cycle
byte_data  input  8  received byte
prg_write_enable  output  1  one-cycle program memory write strobe
prg_byte_address  output  32  byte address of the word being written (word_index*4)
prg_write_data  output  32  packed instruction word
word_count  output  $clog2(MEM_WORDS)+1  number of complete words written so far
load_done  output  1  high and sticky once loading has finished
partial_error  output  1  sticky; timeout fired with 1-3 bytes of an unfinished word buffered
overflow_error  output  1  sticky; a byte arrived while in DONE

Behaviour:
- Reset (asynchronous, active-high): all outputs 0, state=IDLE, byte_index=0, word_index=0, idle counter=0, packing buffer=0.
- States and transitions:
  - IDLE -> RECEIVE on the first byte_valid.
  - IDLE -> DONE on timeout (no program sent).
  - RECEIVE -> DONE when word_index reaches MEM_WORDS, or on timeout.
  - DONE is terminal until reset.
- Packing:
  - byte_index counts 0..3 and wraps.
  - Byte 0 goes to [31:24], byte 1 to [23:16], byte 2 to [15:8], byte 3 to [7:0].
- Write timing:
  - On the cycle after the 4th byte is accepted: prg_write_enable=1 for exactly one cycle, prg_write_data=packed word, prg_byte_address=word_index<<2.
  - word_index and word_count increment in that same cycle.
  - Address and data hold their values between writes. Address bits [1:0] are always 0.
- Back-to-back bytes: a byte may arrive on every cycle, including the cycle the write strobe is high. The packing buffer is separate from the write register, so no byte is lost.
- Idle counter:
  - Clears on every accepted byte and increments otherwise.
  - Saturates at IDLE_TIMEOUT.
  - Timeout condition: counter==IDLE_TIMEOUT and byte_valid=0.
  - If byte_valid and the terminal count occur in the same cycle, the byte wins: it is accepted, the counter clears, and there is no timeout.
- Timeout with byte_index!=0: the partial word is discarded (no write) and partial_error is set.
- Full memory:
  - After the MEM_WORDS-th write, load_done rises on the next cycle.
  - Any later byte_valid sets overflow_error and is otherwise ignored; no further writes occur.
- load_done is registered. It is never asserted in the same cycle as prg_write_enable, and the last write always precedes it by at least 1 cycle.
- In DONE, prg_write_enable=0 permanently and the idle counter stops.
- Reset mid-load: everything returns to the reset state immediately, and already-written memory is not cleared. The next load restarts at address 0.

Decomposition:
- Shared package common: loader_state_t enum {LD_IDLE, LD_RECEIVE, LD_DONE}, plus constants PRG_MEM_WORDS and LOADER_IDLE_TIMEOUT so the top level and the loader agree.
- One natural sub-module: byte_packer (byte_index counter, 32-bit shift/insert buffer, word_ready pulse).
- The FSM, idle counter and write register stay in uart_program_loader.

Test Plan:
- Bytes 0x00,0x50,0x00,0x93 on consecutive cycles -> one write strobe 1 cycle after the last byte: address 0x0, data 0x00500093, word_count=1. Then idle for IDLE_TIMEOUT (8 in the bench) -> load_done=1, no errors.
- 8 bytes 0x11..0x88, one every 3 cycles -> writes 0x11223344 @0x0 and 0x55667788 @0x4; the idle counter clears on each byte, so there is no early done.
- MEM_WORDS=4, 16 bytes back-to-back -> 4 writes at 0x0,0x4,0x8,0xC, load_done the cycle after the 4th write. A 17th byte -> overflow_error=1 and no write.
- 2 bytes 0xAB,0xCD then silence -> no write, load_done=1, partial_error=1, word_count=0.
- byte_valid coincident with the terminal idle count -> byte accepted, load_done stays 0. No bytes at all -> load_done exactly IDLE_TIMEOUT+1 cycles after reset release.
- Reset asserted after 6 bytes (mid-word 2) -> all outputs 0 in the same cycle (asynchronous). Reload of 4 bytes -> write at address 0x0.
